mips_prog_loader: RTL

//  Boot-time program loader upstream of the MIPS core. Accepts a byte stream
//  (header, words, checksum) and writes the words into the unified memory

---
 rtl/mips_prog_loader_if.sv | 42 ++++
 rtl/mips_prog_loader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mips_prog_loader_if.sv
// Byte-stream, memory write port and status bundle
// between the program loader and its environment.
interface mips_prog_loader_if #(
  parameter int ADDR_W = 32
);
  logic              start_i;
  logic              byte_valid_i;
  logic [7:0]        byte_data_i;
  logic              byte_ready_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_waddr_o;
  logic [31:0]       mem_wdata_o;
  logic              core_rst_o;
  logic              done_o;
  logic              err_o;

  modport master (
    output start_i,
    output byte_valid_i,
    output byte_data_i,
    input  byte_ready_o,
    input  mem_we_o,
    input  mem_waddr_o,
    input  mem_wdata_o,
    input  core_rst_o,
    input  done_o,
    input  err_o
  );

  modport slave (
    input  start_i,
    input  byte_valid_i,
    input  byte_data_i,
    output byte_ready_o,
    output mem_we_o,
    output mem_waddr_o,
    output mem_wdata_o,
    output core_rst_o,
    output done_o,
    output err_o
  );
endinterface

// File: rtl/mips_prog_loader.sv
// Boot loader: header/word/checksum byte stream into
// unified memory; holds the core in reset until good.
module mips_prog_loader #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  mips_prog_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [16:0] MaxW = 17'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] Step = ADDR_W'(4);

  state_e            state_q, state_d;
  logic [7:0]        hdr_q, hdr_d;
  logic [15:0]       left_q, left_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       asm_q, asm_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              core_rst_q, core_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic        ready;
  logic        acc;
  logic [15:0] hdr_cnt;
  logic [31:0] asm_nxt;

  assign ready = (state_q != S_DONE) &&
                 (state_q != S_ERR);
  assign acc = bus.byte_valid_i && ready;
  assign hdr_cnt = {hdr_q, bus.byte_data_i};
  assign asm_nxt = {asm_q[23:0], bus.byte_data_i};

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    left_d     = left_q;
    idx_d      = idx_q;
    asm_d      = asm_q;
    csum_d     = csum_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    wdata_d    = wdata_q;
    core_rst_d = core_rst_q;
    done_d     = done_q;
    err_d      = err_q;

    // Address advances the cycle after each write strobe.
    if (we_q) addr_d = addr_q + Step;

    unique case (state_q)
      S_HDR_HI: begin
        if (acc) begin
          hdr_d   = bus.byte_data_i;
          state_d = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (acc) begin
          if ({1'b0, hdr_cnt} > MaxW) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (hdr_cnt == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
            left_d  = hdr_cnt;
          end
        end
      end
      S_DATA: begin
        if (acc) begin
          csum_d = csum_q ^ bus.byte_data_i;
          asm_d  = asm_nxt;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = asm_nxt;
            left_d  = left_q - 16'd1;
            if (left_q == 16'd1) state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (acc) begin
          if (bus.byte_data_i == csum_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            core_rst_d = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (bus.start_i) begin
          state_d    = S_HDR_HI;
          core_rst_d = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          csum_d     = 8'd0;
          addr_d     = BASE_ADDR;
          idx_d      = 2'd0;
        end
      end
      default: state_d = S_HDR_HI;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_HDR_HI;
      hdr_q      <= 8'd0;
      left_q     <= 16'd0;
      idx_q      <= 2'd0;
      asm_q      <= 32'd0;
      csum_q     <= 8'd0;
      addr_q     <= BASE_ADDR;
      we_q       <= 1'b0;
      wdata_q    <= 32'd0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      left_q     <= left_d;
      idx_q      <= idx_d;
      asm_q      <= asm_d;
      csum_q     <= csum_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.byte_ready_o = ready;
  assign bus.mem_we_o     = we_q;
  assign bus.mem_waddr_o  = addr_q;
  assign bus.mem_wdata_o  = wdata_q;
  assign bus.core_rst_o   = core_rst_q;
  assign bus.done_o       = done_q;
  assign bus.err_o        = err_q;

endmodule
